// File: rtl/sd_dev_pkg.sv
// sd_dev_pkg: shared constants and state encoding for the SD device command sequencer.
package sd_dev_pkg;
    localparam logic [5:0] SD_FRAME_BITS = 6'd48;
    localparam logic [5:0] SD_END_IDX    = 6'd47;
    localparam logic [5:0] SD_CRC_BITS   = 6'd40;
    localparam logic [6:0] SD_CRC7_POLY  = 7'h09;
    // Bit positions within a 48-bit frame, MSB (start bit) first on the line
    localparam int SD_POS_START  = 47;
    localparam int SD_POS_TX     = 46;
    localparam int SD_POS_IDX_HI = 45;
    localparam int SD_POS_IDX_LO = 40;
    localparam int SD_POS_ARG_HI = 39;
    localparam int SD_POS_ARG_LO = 8;
    localparam int SD_POS_CRC_HI = 7;
    localparam int SD_POS_CRC_LO = 1;
    localparam int SD_POS_END    = 0;
    typedef logic [2:0] sd_state_t;
    localparam sd_state_t ST_IDLE     = 3'd0;
    localparam sd_state_t ST_RX       = 3'd1;
    localparam sd_state_t ST_CHECK    = 3'd2;
    localparam sd_state_t ST_RSP_WAIT = 3'd3;
    localparam sd_state_t ST_TURN     = 3'd4;
    localparam sd_state_t ST_TX       = 3'd5;
endpackage

// File: rtl/sd_crc7.sv
// sd_crc7: serial CRC7 (x^7+x^3+1); clear and enable together restart the CRC from the given bit.
module sd_crc7
    import sd_dev_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       d,
    output logic [6:0] crc
);
    logic [6:0] base;
    logic       fb;
    always_comb begin
        base = clr ? 7'd0 : crc;
        fb   = d ^ base[6];
    end
    always_ff @(posedge clk) begin
        if (rst) crc <= '0;
        else if (en) crc <= {base[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'd0);
        else if (clr) crc <= '0;
    end
endmodule

// File: rtl/sd_dev_cmd_seq.sv
// sd_dev_cmd_seq: device-side CMD line sequencer; deserializes host commands and serializes responses.
module sd_dev_cmd_seq
    import sd_dev_pkg::*;
#(
    parameter int NCR_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_sd_clk_en,
    input  logic        i_sd_cmd_in,
    output logic        o_sd_cmd_dir,
    output logic        o_sd_cmd_out,
    output logic        o_cmd_stb,
    output logic [5:0]  o_cmd_index,
    output logic [31:0] o_cmd_arg,
    output logic        o_cmd_crc_err,
    input  logic        i_rsp_stb,
    input  logic        i_rsp_none,
    input  logic [5:0]  i_rsp_index,
    input  logic [31:0] i_rsp_arg,
    output logic        o_rsp_busy,
    output logic        o_rsp_done
);
    localparam logic [5:0] NCR_LAST = 6'(NCR_CYCLES - 1);
    sd_state_t   state;
    logic [5:0]  cnt;
    logic [46:0] rx_sr;
    logic [39:0] tx_sr;
    logic [47:0] rx_frame;
    logic [6:0]  rx_crc, tx_crc;
    logic        rx_start, rx_crc_en, tx_crc_en, tx_bit, rx_err;
    always_comb begin
        rx_frame  = {rx_sr, i_sd_cmd_in};
        rx_start  = state == ST_IDLE && !i_sd_cmd_in;
        rx_crc_en = i_sd_clk_en && (rx_start || (state == ST_RX && cnt < SD_CRC_BITS));
        tx_crc_en = i_sd_clk_en && state == ST_TX && cnt < SD_CRC_BITS;
        tx_bit    = cnt < SD_CRC_BITS ? tx_sr[39] :
                    cnt < SD_END_IDX  ? tx_crc[3'd6 - 3'(cnt - SD_CRC_BITS)] : 1'b1;
        rx_err    = (rx_frame[SD_POS_CRC_HI:SD_POS_CRC_LO] != rx_crc) || rx_frame[SD_POS_START] ||
                    !rx_frame[SD_POS_TX] || !rx_frame[SD_POS_END];
    end
    assign o_rsp_busy = state == ST_TURN || state == ST_TX;
    sd_crc7 u_rx_crc (
        .clk(clk), .rst(rst), .clr(state == ST_IDLE), .en(rx_crc_en), .d(i_sd_cmd_in), .crc(rx_crc)
    );
    sd_crc7 u_tx_crc (
        .clk(clk), .rst(rst), .clr(state != ST_TX), .en(tx_crc_en), .d(tx_sr[39]), .crc(tx_crc)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            rx_sr         <= '0;
            tx_sr         <= '0;
            o_sd_cmd_dir  <= 1'b0;
            o_sd_cmd_out  <= 1'b1;
            o_cmd_stb     <= 1'b0;
            o_cmd_index   <= '0;
            o_cmd_arg     <= '0;
            o_cmd_crc_err <= 1'b0;
            o_rsp_done    <= 1'b0;
        end else begin
            o_cmd_stb  <= 1'b0;
            o_rsp_done <= 1'b0;
            case (state)
                ST_IDLE: if (i_sd_clk_en && rx_start) begin
                    state <= ST_RX;
                    cnt   <= 6'd1;
                    rx_sr <= '0;
                end
                ST_RX: if (i_sd_clk_en) begin
                    rx_sr <= {rx_sr[45:0], i_sd_cmd_in};
                    cnt   <= cnt + 6'd1;
                    if (cnt == SD_END_IDX) begin
                        state         <= ST_CHECK;
                        o_cmd_stb     <= 1'b1;
                        o_cmd_index   <= rx_frame[SD_POS_IDX_HI:SD_POS_IDX_LO];
                        o_cmd_arg     <= rx_frame[SD_POS_ARG_HI:SD_POS_ARG_LO];
                        o_cmd_crc_err <= rx_err;
                    end
                end
                ST_CHECK: begin
                    state <= o_cmd_crc_err ? ST_IDLE : ST_RSP_WAIT;
                    cnt   <= '0;
                end
                ST_RSP_WAIT: if (i_rsp_stb) begin
                    state <= ST_TURN;
                    tx_sr <= {2'b00, i_rsp_index, i_rsp_arg};
                    cnt   <= '0;
                end else if (i_rsp_none) state <= ST_IDLE;
                ST_TURN: if (i_sd_clk_en) begin
                    state <= cnt == NCR_LAST ? ST_TX : ST_TURN;
                    cnt   <= cnt == NCR_LAST ? 6'd0 : cnt + 6'd1;
                end
                // cnt reaching 48 means the end bit's period has just completed
                ST_TX: if (i_sd_clk_en) begin
                    if (cnt == SD_FRAME_BITS) begin
                        state        <= ST_IDLE;
                        cnt          <= '0;
                        o_sd_cmd_dir <= 1'b0;
                        o_sd_cmd_out <= 1'b1;
                        o_rsp_done   <= 1'b1;
                    end else begin
                        o_sd_cmd_dir <= 1'b1;
                        o_sd_cmd_out <= tx_bit;
                        tx_sr        <= {tx_sr[38:0], 1'b0};
                        cnt          <= cnt + 6'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_dev_cmd_seq.sv
// tb_sd_dev_cmd_seq: vector table, hand sequences and randomized frames against a polynomial-division model.
module tb_sd_dev_cmd_seq;
    localparam int NCR = 2;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_sd_clk_en = 1'b0;
    logic        i_sd_cmd_in = 1'b1;
    logic        o_sd_cmd_dir, o_sd_cmd_out, o_cmd_stb, o_cmd_crc_err, o_rsp_busy, o_rsp_done;
    logic [5:0]  o_cmd_index;
    logic [31:0] o_cmd_arg;
    logic        i_rsp_stb = 1'b0;
    logic        i_rsp_none = 1'b0;
    logic [5:0]  i_rsp_index = '0;
    logic [31:0] i_rsp_arg = '0;
    int total = 0;
    int bad = 0;
    int stb_cnt = 0;
    int gap_lo = 1;
    int gap_hi = 1;

    sd_dev_cmd_seq #(.NCR_CYCLES(NCR)) dut (
        .clk(clk), .rst(rst), .i_sd_clk_en(i_sd_clk_en), .i_sd_cmd_in(i_sd_cmd_in),
        .o_sd_cmd_dir(o_sd_cmd_dir), .o_sd_cmd_out(o_sd_cmd_out), .o_cmd_stb(o_cmd_stb),
        .o_cmd_index(o_cmd_index), .o_cmd_arg(o_cmd_arg), .o_cmd_crc_err(o_cmd_crc_err),
        .i_rsp_stb(i_rsp_stb), .i_rsp_none(i_rsp_none), .i_rsp_index(i_rsp_index),
        .i_rsp_arg(i_rsp_arg), .o_rsp_busy(o_rsp_busy), .o_rsp_done(o_rsp_done)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (o_cmd_stb) stb_cnt++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (bad=%0d)", bad);
        $fatal(1, "watchdog");
    end

    // Remainder of m * x^7 divided by x^7+x^3+1, by long division
    function automatic logic [6:0] crc7(input logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'd0};
        for (int i = 46; i >= 7; i--) if (r[i]) r = r ^ (47'h89 << (i - 7));
        return r[6:0];
    endfunction

    function automatic logic [47:0] make_frame(input logic tx, input logic [5:0] idx, input logic [31:0] arg);
        return {1'b0, tx, idx, arg, crc7({1'b0, tx, idx, arg}), 1'b1};
    endfunction

    function automatic logic frame_err(input logic [47:0] f);
        return (crc7(f[47:8]) != f[7:1]) || !f[46] || !f[0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic en_tick(input logic b);
        i_sd_cmd_in = b;
        i_sd_clk_en = 1'b1;
        tick();
        i_sd_clk_en = 1'b0;
    endtask

    task automatic gap_ticks();
        int n;
        n = $urandom_range(gap_hi, gap_lo);
        for (int g = 0; g < n; g++) tick();
    endtask

    task automatic rx_check(input string tag, input logic [47:0] f, input logic e_err,
                            input logic [5:0] e_idx, input logic [31:0] e_arg);
        int s0;
        s0 = stb_cnt;
        for (int i = 0; i < 2; i++) begin
            en_tick(1'b1);
            gap_ticks();
        end
        for (int i = 47; i >= 0; i--) begin
            en_tick(f[i]);
            if (i > 0) gap_ticks();
        end
        chk({tag, "_stb"}, o_cmd_stb, 1'b1);
        chk({tag, "_idx"}, o_cmd_index, e_idx);
        chk({tag, "_arg"}, o_cmd_arg, e_arg);
        chk({tag, "_err"}, o_cmd_crc_err, e_err);
        tick();
        chk({tag, "_stb_pulses"}, 64'(stb_cnt - s0), 64'd1);
    endtask

    task automatic do_rsp(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                          input logic both, input logic line, input int rst_at);
        logic [47:0] ef, got;
        logic turn_ok, dir_ok;
        int s0;
        ef = make_frame(1'b0, idx, arg);
        s0 = stb_cnt;
        turn_ok = 1'b1;
        dir_ok = 1'b1;
        got = '0;
        i_rsp_index = idx;
        i_rsp_arg = arg;
        i_rsp_stb = 1'b1;
        i_rsp_none = both;
        tick();
        i_rsp_stb = 1'b0;
        i_rsp_none = 1'b0;
        i_rsp_index = 6'($urandom);
        i_rsp_arg = $urandom;
        chk({tag, "_busy"}, o_rsp_busy, 1'b1);
        for (int k = 0; k < NCR; k++) begin
            en_tick(line);
            if (o_sd_cmd_dir !== 1'b0) turn_ok = 1'b0;
            gap_ticks();
        end
        chk({tag, "_turn_dir0"}, turn_ok, 1'b1);
        for (int k = 0; k < 48; k++) begin
            if (k == rst_at) begin
                chk({tag, "_dir_before_rst"}, o_sd_cmd_dir, 1'b1);
                rst = 1'b1;
                tick();
                rst = 1'b0;
                i_sd_cmd_in = 1'b1;
                chk({tag, "_rst_dir"}, o_sd_cmd_dir, 1'b0);
                chk({tag, "_rst_out"}, o_sd_cmd_out, 1'b1);
                chk({tag, "_rst_busy"}, o_rsp_busy, 1'b0);
                return;
            end
            en_tick(line);
            got[47-k] = o_sd_cmd_out;
            if (o_sd_cmd_dir !== 1'b1) dir_ok = 1'b0;
            gap_ticks();
        end
        chk({tag, "_tx_dir1"}, dir_ok, 1'b1);
        chk({tag, "_tx_bits"}, got, ef);
        en_tick(line);
        chk({tag, "_done"}, o_rsp_done, 1'b1);
        chk({tag, "_end_dir"}, o_sd_cmd_dir, 1'b0);
        chk({tag, "_end_out"}, o_sd_cmd_out, 1'b1);
        tick();
        i_sd_cmd_in = 1'b1;
        chk({tag, "_done_pulse"}, {o_rsp_done, o_rsp_busy}, 2'b00);
        chk({tag, "_no_rx_stb"}, 64'(stb_cnt - s0), 64'd0);
    endtask

    typedef struct {
        logic [47:0] frame;
        logic        err;
        logic [5:0]  idx;
        logic [31:0] arg;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{48'h400000000095, 1'b0, 6'd0, 32'h0};
        vecs[1] = '{48'h48000001AA87, 1'b0, 6'd8, 32'h000001AA};
        vecs[2] = '{48'h48000001AB87, 1'b1, 6'd8, 32'h000001AB};
        vecs[3] = '{48'h400000000094, 1'b1, 6'd0, 32'h0};
        vecs[4] = '{48'h000000000095, 1'b1, 6'd0, 32'h0};
        vecs[5] = '{make_frame(1'b1, 6'd55, 32'h12345678), 1'b0, 6'd55, 32'h12345678};

        tick();
        tick();
        chk("rst_dir", o_sd_cmd_dir, 1'b0);
        chk("rst_out", o_sd_cmd_out, 1'b1);
        chk("rst_stb", o_cmd_stb, 1'b0);
        chk("rst_idx", o_cmd_index, 6'd0);
        chk("rst_arg", o_cmd_arg, 32'd0);
        chk("rst_err", o_cmd_crc_err, 1'b0);
        chk("rst_busy", o_rsp_busy, 1'b0);
        chk("rst_done", o_rsp_done, 1'b0);
        rst = 1'b0;
        tick();

        foreach (vecs[v]) begin
            rx_check($sformatf("vec%0d", v), vecs[v].frame, vecs[v].err, vecs[v].idx, vecs[v].arg);
            if (vecs[v].err) begin
                i_rsp_stb = 1'b1;
                tick();
                i_rsp_stb = 1'b0;
                for (int k = 0; k < 4; k++) en_tick(1'b1);
                chk($sformatf("vec%0d_ignored_rsp", v), {o_sd_cmd_dir, o_rsp_busy}, 2'b00);
            end else begin
                i_rsp_none = 1'b1;
                tick();
                i_rsp_none = 1'b0;
                chk($sformatf("vec%0d_hold_idx", v), o_cmd_index, vecs[v].idx);
                chk($sformatf("vec%0d_none_busy", v), o_rsp_busy, 1'b0);
            end
        end

        rx_check("cmd8", 48'h48000001AA87, 1'b0, 6'd8, 32'h000001AA);
        do_rsp("cmd8_rsp", 6'd8, 32'h000001AA, 1'b0, 1'b1, -1);
        rx_check("both_cmd0", 48'h400000000095, 1'b0, 6'd0, 32'h0);
        do_rsp("both_rsp", 6'h3F, 32'hDEADBEEF, 1'b1, 1'b1, -1);
        rx_check("line_cmd0", 48'h400000000095, 1'b0, 6'd0, 32'h0);
        do_rsp("line_low_rsp", 6'd1, 32'h00FF00FF, 1'b0, 1'b0, -1);
        rx_check("rst_cmd8", 48'h48000001AA87, 1'b0, 6'd8, 32'h000001AA);
        do_rsp("rst_rsp", 6'd8, 32'h000001AA, 1'b0, 1'b1, 20);
        rx_check("post_rst_cmd0", 48'h400000000095, 1'b0, 6'd0, 32'h0);
        i_rsp_none = 1'b1;
        tick();
        i_rsp_none = 1'b0;

        gap_lo = 0;
        gap_hi = 2;
        for (int r = 0; r < 15; r++) begin
            logic [47:0] f;
            logic e;
            int mode;
            f = make_frame(1'b1, 6'($urandom), $urandom);
            if ($urandom_range(2, 0) == 0) f[$urandom_range(46, 0)] ^= 1'b1;
            e = frame_err(f);
            rx_check($sformatf("rnd%0d", r), f, e, f[45:40], f[39:8]);
            if (!e) begin
                mode = $urandom_range(2, 0);
                if (mode == 0) begin
                    i_rsp_none = 1'b1;
                    tick();
                    i_rsp_none = 1'b0;
                    chk($sformatf("rnd%0d_none_busy", r), o_rsp_busy, 1'b0);
                end else begin
                    do_rsp($sformatf("rnd%0d_rsp", r), 6'($urandom), $urandom, mode == 2, 1'b1, -1);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sd_dev_cmd_seq.md
# sd_dev_cmd_seq

SD device-side command-line sequencer between the PHY platform layer and the SDIO function/register logic. Each bit period it samples the shared CMD line and deserializes 48-bit host commands, checking CRC7 and framing. On request from the upper layer it owns the line after the Ncr turnaround and serializes a 48-bit response, including CRC7. It is the only block that drives the platform's CMD direction and output bits.

## Interface
- NCR_CYCLES, 2: bit periods between the command end bit and the response start bit, with the line released (min 2).
- clk  in  1  system clock (the SD-clock x2 domain)
- rst  in  1  synchronous, active-high reset
- i_sd_clk_en  in  1  one-clk pulse per SD clock period; all line sampling and driving is qualified by it
- i_sd_cmd_in  in  1  CMD line value from the PHY
- o_sd_cmd_dir  out  1  1 = device drives CMD
- o_sd_cmd_out  out  1  bit driven when dir=1
- o_cmd_stb  out  1  one-clk pulse: command captured
- o_cmd_index  out  6  captured command index
- o_cmd_arg  out  32  captured argument
- o_cmd_crc_err  out  1  qualifies o_cmd_stb: CRC, transmission-bit or end-bit fault
- i_rsp_stb  in  1  launch a response (accepted only in RSP_WAIT)
- i_rsp_none  in  1  command needs no response; return to IDLE
- i_rsp_index  in  6  response index field, sampled with i_rsp_stb
- i_rsp_arg  in  32  response argument, sampled with i_rsp_stb
- o_rsp_busy  out  1  high from TURN through TX
- o_rsp_done  out  1  one-clk pulse after the end bit's period completes

## Operation
- Frame, MSB first: start 0, transmission bit (host 1 / device 0), index[5:0], arg[31:0], CRC7[6:0], end 1.
- CRC7: polynomial x^7+x^3+1, init 0, computed over the first 40 bits.
- States:
  - IDLE: on an enable with i_sd_cmd_in=0, go to RX with bit counter=1.
  - RX: shift one bit per enable. When the 48th bit is captured, go to CHECK.
  - CHECK: single clk. Pulse o_cmd_stb. Set o_cmd_crc_err = (crc mismatch) | (tx bit != 1) | (end bit != 1). If err, go to IDLE; else go to RSP_WAIT.
  - RSP_WAIT:
    - i_rsp_stb: latch the fields, go to TURN.
    - i_rsp_none: go to IDLE.
    - Both asserted in the same cycle: i_rsp_stb wins.
  - TURN: dir=0 for NCR_CYCLES enables, counted from the first enable after entry, then go to TX.
  - TX: on each enable, drive the next bit with dir=1. On the enable after the end bit, go to IDLE with dir=0 and out=1, and pulse o_rsp_done.
- The CMD line is ignored outside IDLE/RX, so no new command is detected while the device owns or has reserved the line.
- i_rsp_stb/i_rsp_none are ignored outside RSP_WAIT.
- o_cmd_index/o_cmd_arg/o_cmd_crc_err hold their values until the next CHECK.

## Timing
- Reset values: o_sd_cmd_dir=0, o_sd_cmd_out=1, o_cmd_stb=0, o_cmd_index=0, o_cmd_arg=0, o_cmd_crc_err=0, o_rsp_busy=0, o_rsp_done=0. State is IDLE and counters are 0.
- rst mid-frame (RX or TX): line released on the next clk, partial frame discarded, no strobe.
- Command latency: o_cmd_stb is asserted on the clk after the enable that samples the end bit.
- Response: start bit is driven on the (NCR_CYCLES+1)th enable after i_rsp_stb is accepted. 48 enables of drive follow. o_rsp_done is asserted 1 clk after the enable that ends the end-bit period.
- A missing i_sd_clk_en freezes all counters. No timeouts are implemented; the upper layer owns timeouts.

## Structure
- Shared package sd_dev_pkg:
  - state enum (IDLE, RX, CHECK, RSP_WAIT, TURN, TX)
  - SD_FRAME_BITS=48
  - SD_CRC7_POLY=7'h09
  - field bit positions
- Sub-module sd_crc7: serial CRC7 with clear, enable, data-bit inputs and a 7-bit output. Two instances, one for RX and one for TX.

## Test plan
- CMD0 frame 0x400000000095 with one enable every 2 clks → o_cmd_stb, index 0, arg 0, crc_err 0, state RSP_WAIT.
- CMD8 frame 0x48000001AA87, then i_rsp_stb with index 8, arg 0x000001AA →
  - dir stays 0 for 2 bit periods
  - 48 driven bits match the bench CRC7 model, with tx bit 0 and end bit 1
  - o_rsp_done pulses, then dir=0
- CMD8 frame with one flipped arg bit → o_cmd_stb with crc_err=1, returns to IDLE, and a following i_rsp_stb is ignored (dir stays 0).
- i_rsp_stb and i_rsp_none asserted in the same cycle in RSP_WAIT → response is sent.
- rst asserted at bit 20 of TX → next clk dir=0, out=1, busy=0. A subsequent CMD0 is decoded correctly.
- Start bit presented on i_sd_cmd_in during TURN/TX → ignored, no o_cmd_stb.
